sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port arbiter that shares the single physical SRAM between the SLC-3 CPU memory path (MAR/MDR side) and a secondary DMA/program-loader requester.
- Sits between the requesters and the SRAM pins (ADDR, Data_to_SRAM, Data_from_SRAM, OE, WE).
- Sequences each access with a fixed wait count and returns a one-cycle acknowledge.
- Round-robin on simultaneous requests, so neither port starves.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_WAIT, 2, cycles OE/WE held active per access; 0 is illegal and is treated as 1

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, valid from cpu_ack of a read
dma_req  in  1  DMA request, same rules as cpu_req
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  DMA read data, valid from dma_ack of a read
ADDR  out  ADDR_W  SRAM address
Data_to_SRAM  out  DATA_W  SRAM write data
Data_from_SRAM  in  DATA_W  SRAM read data
OE  out  1  SRAM output enable, active-low
WE  out  1  SRAM write enable, active-low
busy  out  1  high whenever state is not IDLE
owner  out  1  port of the current or last grant, 0=CPU, 1=DMA

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; OE=WE=1; both acks 0.
  - ADDR, Data_to_SRAM, cpu_rdata, dma_rdata = 0.
  - last_owner=1, so the CPU wins the first tie; owner=0.
  - Reset mid-transaction aborts it with no ack and no rdata update.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - OE=WE=1.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port != last_owner.
  - On the grant edge, latch addr, wdata, we and owner, set last_owner=owner, load cnt=MEM_WAIT-1, go to ACCESS.
- ACCESS:
  - ADDR = latched addr.
  - Read: OE=0, WE=1.
  - Write: OE=1, WE=0, Data_to_SRAM = latched wdata.
  - Outputs depend only on the latched values; requester inputs may change without effect.
  - cnt decrements each cycle. On the edge where cnt==0, go to DONE; if the access is a read, capture Data_from_SRAM into the owner's rdata register on that same edge.
- DONE:
  - OE=WE=1, one write-recovery/turnaround cycle.
  - Owner's ack=1 for exactly this cycle; the other ack stays 0.
  - Next state is IDLE.
- Latency: request seen at IDLE edge k → ACCESS cycles k+1..k+MEM_WAIT → ack in cycle k+MEM_WAIT+1. Back-to-back throughput is one access per MEM_WAIT+2 cycles.
- Requester rules:
  - req, we, addr and wdata must be stable from assertion until the ack cycle.
  - The requester deasserts req on the edge where it sees ack. A req still high in the following IDLE cycle counts as a new request.
- rdata registers hold until that port's next read completes. Writes never modify rdata.
- ADDR and Data_to_SRAM hold their last latched values in IDLE and DONE.
- OE and WE are never both 0. Both are registered-state decodes, with no combinational path from the req inputs.
- A request arriving in ACCESS or DONE waits and is arbitrated in the next IDLE.

Test Plan:
1. Pulse Reset_n low, hold 0 → OE=1, WE=1, cpu_ack=dma_ack=0, ADDR=x0000, busy=0, cpu_rdata=dma_rdata=x0000.
2. MEM_WAIT=2: cpu_req=1, cpu_we=0, cpu_addr=x0003; SRAM model returns x1234 → OE=0 for exactly 2 cycles with ADDR=x0003, cpu_ack high in cycle 3 after the request edge, cpu_rdata=x1234, dma_ack never high.
3. dma_req write, dma_addr=x0010, dma_wdata=xBEEF → WE=0 for 2 cycles, OE=1 throughout, Data_to_SRAM=xBEEF, dma_ack pulses once, dma_rdata unchanged.
4. After reset, assert cpu_req and dma_req together and keep both re-requesting → grant order CPU, DMA, CPU, DMA (owner toggles); each ack is spaced 4 cycles apart.
5. Drive Reset_n=0 in the second ACCESS cycle of a CPU write → OE=WE=1 immediately, no cpu_ack. Release with cpu_req still high → a fresh full 4-cycle transaction completes.
6. Change dma_addr from x0020 to x0021 during ACCESS of a DMA read → ADDR stays x0020, and dma_rdata holds the data for x0020.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter sharing one asynchronous SRAM between the CPU and a DMA requester.
// Each access holds OE/WE for MEM_WAIT cycles, then a turnaround cycle carries the owner's ack.
module sram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              OE,
  output logic              WE,
  output logic              busy,
  output logic              owner
);

  // A zero wait count would never assert the strobes, so it is promoted to one cycle.
  localparam int unsigned Wait = (MEM_WAIT == 0) ? 1 : MEM_WAIT;
  localparam int unsigned CntW = (Wait > 1) ? $clog2(Wait) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(Wait - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              grant_dma;

  // On a tie the port that did not own the previous grant wins.
  always_comb begin
    grant_dma = dma_req && (!cpu_req || !last_owner_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req || dma_req) begin
            owner_q      <= grant_dma;
            last_owner_q <= grant_dma;
            we_q         <= grant_dma ? dma_we    : cpu_we;
            addr_q       <= grant_dma ? dma_addr  : cpu_addr;
            wdata_q      <= grant_dma ? dma_wdata : cpu_wdata;
            cnt_q        <= CntLoad;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
            if (!we_q) begin
              if (owner_q) dma_rdata_q <= Data_from_SRAM;
              else         cpu_rdata_q <= Data_from_SRAM;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Strobes decode only registered state, so requester inputs never reach the SRAM pins.
  always_comb begin
    OE           = !((state_q == StAccess) && !we_q);
    WE           = !((state_q == StAccess) && we_q);
    cpu_ack      = (state_q == StDone) && !owner_q;
    dma_ack      = (state_q == StDone) && owner_q;
    busy         = (state_q != StIdle);
    owner        = owner_q;
    ADDR         = addr_q;
    Data_to_SRAM = wdata_q;
    cpu_rdata    = cpu_rdata_q;
    dma_rdata    = dma_rdata_q;
  end

endmodule
